// File: rtl/abs_pkg.sv
// Shared definitions for the magnitude/sign datapath blocks (abs16, sign_apply16).
package abs_pkg;
    localparam int          W       = 16;
    localparam logic [15:0] MAX_POS = 16'h7FFF;
    localparam logic [15:0] MIN_NEG = 16'h8000;

    typedef struct packed {
        logic [15:0] x;
        logic        cin;
        logic        sign;
        logic        ovf;
    } sa_s1_t;
endpackage

// File: rtl/padder16.sv
// 16-bit ripple adder with carry in/out.
module padder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
endmodule

// File: rtl/sign_apply16.sv
// Rebuilds a 16-bit two's-complement value from magnitude + sign; 2-stage valid/ready pipeline.
// Optional saturation on overflow when SIGN_APPLY_SAT_EN is defined.
module sign_apply16
    import abs_pkg::*;
#(
    parameter int W = abs_pkg::W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_mag,
    input  logic                in_sign,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_data,
    output logic                out_ovf
);
    sa_s1_t             s1_p1;
    logic               vld_p1;
    logic               vld_p2;
    logic               adv1;
    logic               adv2;
    logic [W-1:0]       sum;
    logic               cout_unused;
    logic signed [W-1:0] result;

    function automatic logic signed [W-1:0] sat_value(input logic sign);
        return sign ? $signed(MIN_NEG) : $signed(MAX_POS);
    endfunction

    assign adv2     = !vld_p2 || out_ready;
    assign adv1     = !vld_p1 || adv2;
    assign in_ready = adv1;

    // Stage 1: conditional one's complement, carry-in and overflow detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (adv1) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            s1_p1.x    <= in_mag ^ {W{in_sign}};
            s1_p1.cin  <= in_sign;
            s1_p1.sign <= in_sign;
            s1_p1.ovf  <= in_sign ? (in_mag > MIN_NEG) : in_mag[W-1];
        end
    end

    padder16 u_padder (
        .a    (s1_p1.x),
        .b    (16'h0000),
        .cin  (s1_p1.cin),
        .sum  (sum),
        .cout (cout_unused)
    );

`ifdef SIGN_APPLY_SAT_EN
    assign result = s1_p1.ovf ? sat_value(s1_p1.sign) : $signed(sum);
`else
    assign result = $signed(sum);
`endif

    // Stage 2: increment result (out_data is reset because it is visible on the bus)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_data <= result;
                out_ovf  <= s1_p1.ovf;
            end
        end
    end

    assign out_valid = vld_p2;
endmodule
